// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the MMU port arbiter.
//   - arb_state_e : sequencer states (idle, issue, wait, done)
//   - req_id_e    : requester identity (fetch, load/store)
//   - MEM_ARB_ADDR_W / MEM_ARB_DATA_W : default address/data widths
//   - BYTESEL_ALL : byte enables used for every fetch
package mem_arb_pkg;

   localparam int unsigned MEM_ARB_ADDR_W = 7;
   localparam int unsigned MEM_ARB_DATA_W = 32;
   localparam logic [3:0]  BYTESEL_ALL    = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } arb_state_e;

   typedef enum logic {
      ReqIf = 1'b0,
      ReqLs = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way grant for the MMU port arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin on ties; without it ls always wins.
// Ports:
//   soc_clk, reset : clock and synchronous active-high reset (pointer only)
//   if_req, ls_req : pending requests
//   grant_en       : the arbiter is taking a grant this cycle
//   grant_valid    : at least one request pending
//   grant_ls       : 1 = load/store wins, 0 = fetch wins
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic soc_clk,
   input  logic reset,
   input  logic if_req,
   input  logic ls_req,
   input  logic grant_en,
   output logic grant_valid,
   output logic grant_ls
);

   assign grant_valid = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
   // Remembers whether ls took the last grant; reset to 1 so fetch wins the first tie.
   logic last_ls_q;

   always_ff @(posedge soc_clk) begin
      if (reset) begin
         last_ls_q <= 1'b1;
      end else if (grant_en && grant_valid) begin
         last_ls_q <= grant_ls;
      end
   end

   always_comb begin
      grant_ls = ls_req;
      if (if_req && ls_req) begin
         grant_ls = ~last_ls_q;
      end
   end
`else
   // Fixed priority: no pointer state, so clock/reset/grant_en are not needed.
   logic unused_rr;
   assign unused_rr = ^{soc_clk, reset, grant_en};
   assign grant_ls  = ls_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single MMU/SRAM port between instruction fetch and load/store.
// Each request becomes one registered single-cycle retrieve; after RD_LAT cycles the read
// data is captured and the winner gets a one-cycle done strobe.
// Build option: MEM_ARB_RR_EN (round-robin tie-break, see mem_arb_pick).
// Ports:
//   soc_clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr/if_done              : fetch requester (read, all byte lanes)
//   ls_req/ls_we/ls_addr/ls_bytesel/
//   ls_wdata/ls_done                    : load/store requester
//   rdata                               : read data, valid while a done is high
//   mmu_address/bytesel/wdata/rw/retrieve : registered request to the MMU
//   mmu_rdata                           : MMU read data, valid RD_LAT cycles after retrieve
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
   parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
   input  logic              soc_clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [3:0]        ls_bytesel,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mmu_address,
   output logic [3:0]        mmu_bytesel,
   output logic [DATA_W-1:0] mmu_wdata,
   output logic              mmu_rw,
   output logic              mmu_retrieve,
   input  logic [DATA_W-1:0] mmu_rdata
);

   // Counter is loaded in ISSUE and reaches 0 in the cycle mmu_rdata becomes valid.
   localparam logic [2:0] CntLoad = 3'(RD_LAT - 1);

   arb_state_e        state_q, state_d;
   req_id_e           winner_q;
   logic [2:0]        cnt_q, cnt_d;
   logic              latch, capture;
   logic              grant_valid, grant_ls;

   logic [ADDR_W-1:0] address_q;
   logic [3:0]        bytesel_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rw_q;
   logic [DATA_W-1:0] rdata_q;

   mem_arb_pick u_pick (
      .soc_clk     (soc_clk),
      .reset       (reset),
      .if_req      (if_req),
      .ls_req      (ls_req),
      .grant_en    (state_q == StIdle),
      .grant_valid (grant_valid),
      .grant_ls    (grant_ls)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               latch   = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = CntLoad;
            state_d = StWait;
         end
         StWait: begin
            if (cnt_q == 3'd0) begin
               capture = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge soc_clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge soc_clk) begin
      if (reset) begin
         winner_q  <= ReqIf;
         address_q <= '0;
         bytesel_q <= 4'b0000;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (latch) begin
            if (grant_ls) begin
               winner_q  <= ReqLs;
               address_q <= ls_addr;
               bytesel_q <= ls_bytesel;
               wdata_q   <= ls_wdata;
               rw_q      <= ls_we;
            end else begin
               // Fetch is always a full-word read.
               winner_q  <= ReqIf;
               address_q <= if_addr;
               bytesel_q <= BYTESEL_ALL;
               wdata_q   <= '0;
               rw_q      <= 1'b0;
            end
         end
         if (capture) begin
            rdata_q <= mmu_rdata;
         end
      end
   end

   assign mmu_retrieve = (state_q == StIssue);
   assign if_done      = (state_q == StDone) && (winner_q == ReqIf);
   assign ls_done      = (state_q == StDone) && (winner_q == ReqLs);
   assign mmu_address  = address_q;
   assign mmu_bytesel  = bytesel_q;
   assign mmu_wdata    = wdata_q;
   assign mmu_rw       = rw_q;
   assign rdata        = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A transaction-level model predicts, from cycle arithmetic on grant times, when retrieve and
// done must appear and what the mmu_* registers and rdata must hold; a compare process checks
// the main DUT every cycle. Directed tests pin the model with literal expectations. Two extra
// instances built with RD_LAT=1 and RD_LAT=7 check the latency extremes.
// Honours MEM_ARB_RR_EN the same way the design does.
module tb_mem_arbiter;

   localparam int unsigned RD_LAT = 2;
   localparam int          LAT    = RD_LAT;

   logic        soc_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        if_req  = 1'b0;
   logic [6:0]  if_addr = '0;
   logic        if_done;
   logic        ls_req  = 1'b0;
   logic        ls_we   = 1'b0;
   logic [6:0]  ls_addr = '0;
   logic [3:0]  ls_bytesel = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_done;
   logic [31:0] rdata;
   logic [6:0]  mmu_address;
   logic [3:0]  mmu_bytesel;
   logic [31:0] mmu_wdata;
   logic        mmu_rw;
   logic        mmu_retrieve;
   logic [31:0] mmu_rdata;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   always #5 soc_clk = ~soc_clk;
   always @(posedge soc_clk) cyc <= cyc + 1;

   function automatic logic [31:0] rom(input logic [6:0] a);
      if (a[6:2] == 5'd4) return 32'hDEADBEEF;
      return {8'h5A, 3'b000, a[6:2], 8'hC3, 3'b000, ~a[6:2]};
   endfunction

   function automatic logic [31:0] junk(input int c);
      return 32'hBAD0_0000 ^ 32'(c);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   mem_arbiter #(.RD_LAT(RD_LAT), .ADDR_W(7), .DATA_W(32)) u_dut (
      .soc_clk      (soc_clk),
      .reset        (reset),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_done      (if_done),
      .ls_req       (ls_req),
      .ls_we        (ls_we),
      .ls_addr      (ls_addr),
      .ls_bytesel   (ls_bytesel),
      .ls_wdata     (ls_wdata),
      .ls_done      (ls_done),
      .rdata        (rdata),
      .mmu_address  (mmu_address),
      .mmu_bytesel  (mmu_bytesel),
      .mmu_wdata    (mmu_wdata),
      .mmu_rw       (mmu_rw),
      .mmu_retrieve (mmu_retrieve),
      .mmu_rdata    (mmu_rdata)
   );

   // MMU: data is only valid exactly RD_LAT cycles after the retrieve cycle.
   int         mmu_due   = -1;
   logic [6:0] mmu_raddr = '0;
   always @(posedge soc_clk) begin
      if (mmu_retrieve) begin
         mmu_due   <= cyc + LAT;
         mmu_raddr <= mmu_address;
      end
   end
   assign mmu_rdata = (cyc == mmu_due) ? rom(mmu_raddr) : junk(cyc);

   // Transaction model: a grant at IDLE cycle g gives retrieve at g+1, done at g+LAT+2,
   // and the next IDLE at g+LAT+3.
   bit          m_valid  = 1'b0;
   bit          m_active = 1'b0;
   bit          m_win_ls = 1'b0;
   bit          m_rw     = 1'b0;
   int          m_grant  = 0;
   int          m_free   = 0;
   logic [6:0]  m_addr   = '0;
   logic [3:0]  m_bs     = '0;
   logic [31:0] m_wd     = '0;
   logic [31:0] m_rdata  = '0;
`ifdef MEM_ARB_RR_EN
   bit          m_last_ls = 1'b1;
`endif

   initial forever begin
      @(posedge soc_clk);
      if (reset) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_free   = cyc + 1;
         m_addr   = '0;
         m_bs     = '0;
         m_wd     = '0;
         m_rw     = 1'b0;
`ifdef MEM_ARB_RR_EN
         m_last_ls = 1'b1;
`endif
      end else if (m_valid && cyc >= m_free && (if_req || ls_req)) begin
`ifdef MEM_ARB_RR_EN
         m_win_ls  = (if_req && ls_req) ? !m_last_ls : ls_req;
         m_last_ls = m_win_ls;
`else
         m_win_ls = ls_req;
`endif
         m_active = 1'b1;
         m_grant  = cyc;
         m_free   = cyc + LAT + 3;
         m_addr   = m_win_ls ? ls_addr : if_addr;
         m_bs     = m_win_ls ? ls_bytesel : 4'hF;
         m_rw     = m_win_ls && ls_we;
         m_wd     = ls_wdata;
         m_rdata  = rom(m_addr);
      end
   end

   initial forever begin
      bit exp_ret, exp_done;
      @(negedge soc_clk);
      if (m_valid) begin
         exp_ret  = m_active && (cyc == m_grant + 1);
         exp_done = m_active && (cyc == m_grant + LAT + 2);
         check("retrieve", mmu_retrieve, exp_ret);
         check("if_done", if_done, exp_done && !m_win_ls);
         check("ls_done", ls_done, exp_done && m_win_ls);
         check("mmu_address", mmu_address, m_addr);
         check("mmu_bytesel", mmu_bytesel, m_bs);
         check("mmu_rw", mmu_rw, m_rw);
         if (m_rw) check("mmu_wdata", mmu_wdata, m_wd);
         if (exp_done && !m_rw) check("rdata", rdata, m_rdata);
      end
   end

   typedef struct {
      int          c;
      logic [6:0]  a;
      logic [3:0]  bs;
      logic        rw;
      logic [31:0] wd;
   } ret_t;
   ret_t ret_q[$];
   int   if_done_cnt = 0;

   initial forever begin
      @(negedge soc_clk);
      if (mmu_retrieve) ret_q.push_back('{cyc, mmu_address, mmu_bytesel, mmu_rw, mmu_wdata});
      if (if_done) if_done_cnt++;
   end

   // Callers start these right after a rising edge; req is held for n completions.
   task automatic run_if(input int n, input logic [6:0] a, output int lat, output logic [31:0] rd);
      int start, got;
      start = cyc;
      got   = 0;
      lat   = -1;
      rd    = '0;
      if_addr = a;
      if_req  = 1'b1;
      for (int i = 0; i < 100 && got < n; i++) begin
         @(negedge soc_clk);
         if (if_done) begin
            if (got == 0) begin
               lat = cyc - start;
               rd  = rdata;
            end
            got++;
         end
      end
      check("if_completions", got, n);
      @(posedge soc_clk);
      #1;
      if_req = 1'b0;
   endtask

   task automatic run_ls(input int n, input logic we, input logic [6:0] a, input logic [3:0] bs,
                         input logic [31:0] wd, output int lat);
      int start, got;
      start = cyc;
      got   = 0;
      lat   = -1;
      ls_we      = we;
      ls_addr    = a;
      ls_bytesel = bs;
      ls_wdata   = wd;
      ls_req     = 1'b1;
      for (int i = 0; i < 100 && got < n; i++) begin
         @(negedge soc_clk);
         if (ls_done) begin
            if (got == 0) lat = cyc - start;
            got++;
         end
      end
      check("ls_completions", got, n);
      @(posedge soc_clk);
      #1;
      ls_req = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_retrieve"}, mmu_retrieve, 1'b0);
      check({tag, "_if_done"}, if_done, 1'b0);
      check({tag, "_ls_done"}, ls_done, 1'b0);
      check({tag, "_rw"}, mmu_rw, 1'b0);
      check({tag, "_address"}, mmu_address, 7'h00);
      check({tag, "_bytesel"}, mmu_bytesel, 4'h0);
      check({tag, "_wdata"}, mmu_wdata, 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
   endtask

   // Latency-extreme instances: one fetch of address 7'h10 each.
   bit lat_go = 1'b0;
   bit lat_fin [2];

   for (genvar k = 0; k < 2; k++) begin : g_lat
      localparam int LAT_K = (k == 0) ? 1 : 7;
      logic        req = 1'b0;
      logic        done_if, done_ls, ret, rw;
      logic [6:0]  addr;
      logic [3:0]  bs;
      logic [31:0] wd, rd, mrd;
      int          due   = -1;
      logic [6:0]  raddr = '0;

      mem_arbiter #(.RD_LAT(LAT_K), .ADDR_W(7), .DATA_W(32)) u_dut (
         .soc_clk      (soc_clk),
         .reset        (reset),
         .if_req       (req),
         .if_addr      (7'h10),
         .if_done      (done_if),
         .ls_req       (1'b0),
         .ls_we        (1'b0),
         .ls_addr      (7'h00),
         .ls_bytesel   (4'h0),
         .ls_wdata     (32'h0),
         .ls_done      (done_ls),
         .rdata        (rd),
         .mmu_address  (addr),
         .mmu_bytesel  (bs),
         .mmu_wdata    (wd),
         .mmu_rw       (rw),
         .mmu_retrieve (ret),
         .mmu_rdata    (mrd)
      );

      always @(posedge soc_clk) begin
         if (ret) begin
            due   <= cyc + LAT_K;
            raddr <= addr;
         end
      end
      assign mrd = (cyc == due) ? rom(raddr) : junk(cyc);

      initial begin
         int          start, lat;
         logic [31:0] got_rd;
         lat    = -1;
         got_rd = '0;
         wait (lat_go);
         @(posedge soc_clk);
         #1;
         req   = 1'b1;
         start = cyc;
         for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge soc_clk);
            if (done_if) begin
               lat    = cyc - start;
               got_rd = rd;
            end
         end
         check($sformatf("lat%0d_done_cycle", LAT_K), lat, LAT_K + 2);
         check($sformatf("lat%0d_rdata", LAT_K), got_rd, 32'hDEADBEEF);
         check($sformatf("lat%0d_ls_done", LAT_K), done_ls, 1'b0);
         @(posedge soc_clk);
         #1;
         req        = 1'b0;
         lat_fin[k] = 1'b1;
      end
   end

   initial begin
      int          lat, base, dn;
      logic [31:0] rd;
      logic [6:0]  exp_order [4];

      repeat (3) @(posedge soc_clk);
      #1;
      reset = 1'b0;
      @(negedge soc_clk);
      check_zero("reset");

      // Fetch read.
      @(posedge soc_clk);
      #1;
      base = ret_q.size();
      dn   = cyc;
      run_if(1, 7'h10, lat, rd);
      check("fetch_latency", lat, 4);
      check("fetch_rdata", rd, 32'hDEADBEEF);
      check("fetch_n_retrieve", ret_q.size() - base, 1);
      check("fetch_retrieve_cycle", ret_q[base].c - dn, 1);
      check("fetch_addr", ret_q[base].a, 7'h10);
      check("fetch_bytesel", ret_q[base].bs, 4'hF);
      check("fetch_rw", ret_q[base].rw, 1'b0);

      // Store.
      @(posedge soc_clk);
      #1;
      base = ret_q.size();
      dn   = if_done_cnt;
      run_ls(1, 1'b1, 7'h24, 4'b0011, 32'h0000A5A5, lat);
      check("store_latency", lat, 4);
      check("store_n_retrieve", ret_q.size() - base, 1);
      check("store_addr", ret_q[base].a, 7'h24);
      check("store_bytesel", ret_q[base].bs, 4'b0011);
      check("store_rw", ret_q[base].rw, 1'b1);
      check("store_wdata", ret_q[base].wd, 32'h0000A5A5);
      check("store_no_if_done", if_done_cnt - dn, 0);

      // Simultaneous requests, each side held for two transactions.
`ifdef MEM_ARB_RR_EN
      exp_order = '{7'h40, 7'h50, 7'h40, 7'h50};
`else
      exp_order = '{7'h50, 7'h50, 7'h40, 7'h40};
`endif
      @(posedge soc_clk);
      #1;
      base = ret_q.size();
      fork
         begin
            int          l1;
            logic [31:0] r1;
            run_if(2, 7'h40, l1, r1);
         end
         begin
            int l2;
            run_ls(2, 1'b0, 7'h50, 4'hF, 32'h0, l2);
         end
      join
      check("tie_n_retrieve", ret_q.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (ret_q.size() > base + i) check($sformatf("tie_grant%0d", i), ret_q[base + i].a,
                                            exp_order[i]);
      end

      // Load/store request held high across three completions.
      @(posedge soc_clk);
      #1;
      base = ret_q.size();
      run_ls(3, 1'b0, 7'h08, 4'hF, 32'h0, lat);
      check("held_n_retrieve", ret_q.size() - base, 3);
      if (ret_q.size() >= base + 3) begin
         check("held_spacing0", ret_q[base + 1].c - ret_q[base].c, 5);
         check("held_spacing1", ret_q[base + 2].c - ret_q[base + 1].c, 5);
      end

      // Reset while waiting on the SRAM: no done, outputs cleared, then normal service.
      @(posedge soc_clk);
      #1;
      if_addr = 7'h10;
      if_req  = 1'b1;
      @(posedge soc_clk);
      #1;
      @(posedge soc_clk);
      #1;
      reset  = 1'b1;
      if_req = 1'b0;
      @(posedge soc_clk);
      #1;
      reset = 1'b0;
      @(negedge soc_clk);
      check_zero("abort");
      dn = if_done_cnt;
      repeat (6) @(negedge soc_clk);
      check("abort_no_done", if_done_cnt - dn, 0);
      @(posedge soc_clk);
      #1;
      run_if(1, 7'h10, lat, rd);
      check("after_abort_latency", lat, 4);
      check("after_abort_rdata", rd, 32'hDEADBEEF);

      // Latency extremes.
      lat_go = 1'b1;
      for (int i = 0; i < 60 && !(lat_fin[0] && lat_fin[1]); i++) @(posedge soc_clk);
      check("lat_instances_finished", lat_fin[0] && lat_fin[1], 1'b1);

      repeat (2) @(posedge soc_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
